// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the elastic pipeline register chain.
package pipe_pkg;

    localparam int PIPE_DEFAULT_WIDTH = 32;
    localparam int PIPE_DEFAULT_DEPTH = 2;

    // Occupancy must count 0..DEPTH+1 when the optional skid entry is present.
    function automatic int pipe_occ_width(input int depth);
        return $clog2(depth + 2);
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One elastic stage: a valid bit plus payload. Payload only changes when a
// valid entry is loaded, so empty stages keep their last value.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int WIDTH = PIPE_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            if (clear) begin
                valid <= 1'b0;
            end else if (load) begin
                valid <= src_valid;
            end
            if (!clear && load && src_valid) begin
                data <= src_data;
            end
        end
    end

endmodule

// File: rtl/pipe_elastic_chain.sv
// Elastic register chain of DEPTH stages with bubble collapsing and flush.
// Define PIPE_ELASTIC_SKID_EN to add a one-entry input skid that registers in_ready.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid never depends on ready, and in_ready may depend on out_ready
// combinationally only when the skid entry is not built in.
module pipe_elastic_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH = PIPE_DEFAULT_WIDTH,
    parameter int DEPTH = PIPE_DEFAULT_DEPTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [WIDTH-1:0]                  in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [WIDTH-1:0]                  out_data,
    output logic [pipe_occ_width(DEPTH)-1:0]  occupancy
);

    localparam int OCC_W = pipe_occ_width(DEPTH);

    logic [DEPTH-1:0] valid;
    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH:0]   adv;
    logic [DEPTH-1:0] src_valid;
    logic [WIDTH-1:0] src_data [DEPTH];
    logic             in_fire;
    logic             out_fire;
    logic             head_valid;
    logic [WIDTH-1:0] head_data;

    // A stage may take new contents when it is empty or its contents move on.
    always_comb begin
        adv        = '0;
        adv[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            adv[i] = !valid[i] || adv[i+1];
        end
    end

`ifdef PIPE_ELASTIC_SKID_EN
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;

    assign in_ready   = !skid_valid && !flush;
    assign in_fire    = in_valid && in_ready;
    assign head_valid = skid_valid || in_fire;
    assign head_data  = skid_valid ? skid_data : in_data;

    // in_fire implies the skid is empty, so fill and drain never coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (flush) begin
            skid_valid <= 1'b0;
        end else if (skid_valid && adv[0]) begin
            skid_valid <= 1'b0;
        end else if (in_fire && !adv[0]) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
        end
    end
`else
    assign in_ready   = adv[0] && !flush && !rst;
    assign in_fire    = in_valid && in_ready;
    assign head_valid = in_fire;
    assign head_data  = in_data;
`endif

    always_comb begin
        src_valid[0] = head_valid;
        src_data[0]  = head_data;
        for (int i = 1; i < DEPTH; i++) begin
            src_valid[i] = valid[i-1];
            src_data[i]  = data[i-1];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        pipe_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .clear    (flush),
            .load     (adv[g]),
            .src_valid(src_valid[g]),
            .src_data (src_data[g]),
            .valid    (valid[g]),
            .data     (data[g])
        );
    end

    assign out_valid = valid[DEPTH-1];
    assign out_data  = data[DEPTH-1];
    assign out_fire  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            occupancy <= '0;
        end else begin
            case ({in_fire, out_fire})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_elastic_chain.sv
// Directed bench for pipe_elastic_chain (DEPTH=3) with an entry-position model
// checked every cycle; honours PIPE_ELASTIC_SKID_EN like the design.
module tb_pipe_elastic_chain;

    localparam int WIDTH = 32;
    localparam int DEPTH = 3;
`ifdef PIPE_ELASTIC_SKID_EN
    localparam int CAP = DEPTH + 1;
`else
    localparam int CAP = DEPTH;
`endif

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       occupancy;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    // Model: each accepted entry and its position (-1 = waiting at the input/skid).
    logic [WIDTH-1:0] exp_q[$];
    int               pos_q[$];

    pipe_elastic_chain #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .occupancy(occupancy)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_out_valid();
        return (pos_q.size() > 0) && (pos_q[0] == DEPTH - 1);
    endfunction

    // Each entry moves one place forward unless the place ahead stays taken.
    function automatic int next_ceiling();
        int ceil;
        int first;
        ceil  = DEPTH - 1;
        first = (model_out_valid() && out_ready) ? 1 : 0;
        for (int i = first; i < pos_q.size(); i++) begin
            int np;
            np   = (pos_q[i] + 1 < ceil) ? pos_q[i] + 1 : ceil;
            ceil = np - 1;
        end
        return ceil;
    endfunction

    function automatic bit model_in_ready();
`ifdef PIPE_ELASTIC_SKID_EN
        return !((pos_q.size() > 0) && (pos_q[pos_q.size()-1] < 0)) && !flush;
`else
        return (next_ceiling() >= 0) && !flush && !rst;
`endif
    endfunction

    task automatic model_step();
        bit acc;
        int ceil;
        if (rst || flush) begin
            exp_q.delete();
            pos_q.delete();
            return;
        end
        acc = in_valid && model_in_ready();
        if (model_out_valid() && out_ready) begin
            void'(exp_q.pop_front());
            void'(pos_q.pop_front());
        end
        ceil = DEPTH - 1;
        for (int i = 0; i < pos_q.size(); i++) begin
            pos_q[i] = (pos_q[i] + 1 < ceil) ? pos_q[i] + 1 : ceil;
            ceil     = pos_q[i] - 1;
        end
        if (acc) begin
            exp_q.push_back(in_data);
            pos_q.push_back((ceil < 0) ? ceil : 0);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("out_valid", {31'd0, out_valid}, {31'd0, model_out_valid()});
                if (model_out_valid()) check("out_data", out_data, exp_q[0]);
                check("in_ready", {31'd0, in_ready}, {31'd0, model_in_ready()});
                check("occupancy", {29'd0, occupancy}, exp_q.size());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 0;
        out_ready = 1;
        repeat (DEPTH + 3) step();
    endtask

    initial begin
        rst = 1; flush = 0; in_valid = 0; in_data = '0; out_ready = 0;
        repeat (3) step();
        rst = 0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_occupancy", {29'd0, occupancy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk_en = 1;

        // Back-to-back stream with the sink always ready.
        out_ready = 1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1; in_data = i;
            step();
            if (i == 3) begin
                check("stream_first_valid", {31'd0, out_valid}, 32'd1);
                check("stream_first_data", out_data, 32'h1);
                check("stream_occ3", {29'd0, occupancy}, 32'd3);
            end
            if (i == 5) begin
                check("stream_third_data", out_data, 32'h3);
                check("stream_occ5", {29'd0, occupancy}, 32'd3);
            end
        end
        drain();

        // Full stall: only CAP of five pushes get in.
        out_ready = 0;
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1; in_data = 32'h10 + i;
            step();
        end
        in_valid = 0;
        #1;
        check("stall_occ", {29'd0, occupancy}, CAP);
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        check("stall_head", out_data, 32'h11);
        drain();

        // Bubble collapse under stall.
        out_ready = 0;
        in_valid = 1; in_data = 32'hA; step();
        in_valid = 0; step(); step();
        in_valid = 1; in_data = 32'hB; step();
        in_valid = 0; step();
        check("bubble_occ", {29'd0, occupancy}, 32'd2);
        check("bubble_head", out_data, 32'hA);
        drain();

        // Flush a full chain while 0xF is offered.
        out_ready = 0;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1; in_data = 32'h30 + i;
            step();
        end
        in_data = 32'hF; flush = 1;
        #1;
        check("flush_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        flush = 0; in_valid = 0;
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_occ", {29'd0, occupancy}, 32'd0);
        drain();

        // Reset mid-stream with a toggling sink, then a clean restart.
        for (int i = 0; i < 6; i++) begin
            in_valid = 1; in_data = 32'h40 + i; out_ready = i[0];
            step();
        end
        rst = 1; step();
        rst = 0; in_valid = 0;
        #1;
        check("rst2_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst2_out_data", out_data, 32'd0);
        check("rst2_occ", {29'd0, occupancy}, 32'd0);
        check("rst2_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1; in_data = 32'h20 + i;
            step();
            if (i == 2) check("restart_first", out_data, 32'h20);
        end
        drain();

        // Patterned valid/ready mix checked by the model alone.
        for (int i = 0; i < 200; i++) begin
            in_valid  = (i % 5) != 2;
            out_ready = (i % 3) != 0 && (i % 7) != 4;
            in_data   = 32'h100 + i;
            flush     = (i == 137);
            step();
        end
        flush = 0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
